// File: rtl/rob_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
// Ids are ROB_SIZE_WIDTH bits wide; id 0 means "no entry".
package rob_buffer_pkg;

    localparam int ROB_SIZE_WIDTH = 3;
    localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;

    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    localparam rob_id_t ROB_ID_NONE   = rob_id_t'(0);
    localparam rob_id_t ROB_ID_FIRST  = rob_id_t'(1);
    localparam rob_id_t ROB_COUNT_MAX = '1;

    typedef struct packed {
        logic [4:0]  rd;
        logic        is_br;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_meta_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } rob_lookup_t;

endpackage

// File: rtl/rob_buffer_ptr_inc.sv
// Ring pointer increment for the reorder buffer: wraps from the last id
// back to id 1, never producing the reserved id 0.
module rob_ptr_inc
    import rob_buffer_pkg::*;
(
    input  logic [ROB_SIZE_WIDTH-1:0] ptr_in,
    output logic [ROB_SIZE_WIDTH-1:0] ptr_out
);

    always_comb begin
        ptr_out = ptr_in + rob_id_t'(1);
        if (ptr_out == ROB_ID_NONE) begin
            ptr_out = ROB_ID_FIRST;
        end
    end

endmodule

// File: rtl/rob_buffer.sv
// In-order reorder buffer: allocates ids at issue, captures CDB results,
// retires in program order and flushes on a branch mispredict at commit.
// Optional macro ROB_BYPASS_EN forwards a same-cycle CDB hit to the lookups.
module rob_buffer
    import rob_buffer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic                      issue_has_rd,
    input  logic [4:0]                issue_rd_in,
    input  logic                      issue_is_br,
    input  logic                      issue_pred_taken,
    input  logic [31:0]               issue_alt_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic [4:0]                issue_rd,
    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
    input  logic [31:0]               cdb_value,
    input  logic                      cdb_taken,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
    output logic [31:0]               get_value1,
    output logic [31:0]               get_value2,
    output logic                      get_ready1,
    output logic                      get_ready2,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic                      flush,
    output logic [31:0]               flush_pc
);

    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    logic [ROB_SIZE-1:0] taken_q, taken_d;
    logic [31:0]         value_q [ROB_SIZE];
    logic [31:0]         value_d [ROB_SIZE];
    rob_meta_t           meta_q  [ROB_SIZE];
    rob_meta_t           meta_d  [ROB_SIZE];

    rob_id_t head_q, head_d, tail_q, tail_d, count_q, count_d;
    rob_id_t head_inc, tail_inc;

    rob_id_t     commit_rob_id_q, commit_rob_id_d;
    logic [4:0]  commit_rd_q, commit_rd_d;
    logic [31:0] commit_value_q, commit_value_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_pc_q, flush_pc_d;

    logic      issue_fire;
    logic      commit_fire;
    logic      cdb_hit;
    logic      mispredict;
    rob_meta_t head_meta;

    rob_ptr_inc u_head_inc (.ptr_in(head_q), .ptr_out(head_inc));
    rob_ptr_inc u_tail_inc (.ptr_in(tail_q), .ptr_out(tail_inc));

    function automatic rob_lookup_t lookup(
        input rob_id_t            id,
        input logic [ROB_SIZE-1:0] rdy_vec,
        input logic [31:0]        val,
        input logic               byp_valid,
        input rob_id_t            byp_id,
        input logic [31:0]        byp_value
    );
        rob_lookup_t r;
        r.ready = 1'b0;
        r.value = '0;
        if (id != ROB_ID_NONE) begin
            r.ready = rdy_vec[id];
            r.value = val;
`ifdef ROB_BYPASS_EN
            if (byp_valid && byp_id == id) begin
                r.ready = 1'b1;
                r.value = byp_value;
            end
`else
            if (byp_valid && byp_id == id && byp_value == val) begin
                r.ready = rdy_vec[id];
            end
`endif
        end
        return r;
    endfunction

    rob_lookup_t look1, look2;

    always_comb begin
        look1 = lookup(ask_rob_id1, ready_q, value_q[ask_rob_id1],
                       cdb_valid, cdb_rob_id, cdb_value);
        look2 = lookup(ask_rob_id2, ready_q, value_q[ask_rob_id2],
                       cdb_valid, cdb_rob_id, cdb_value);
    end

    assign get_ready1 = look1.ready;
    assign get_value1 = look1.value;
    assign get_ready2 = look2.ready;
    assign get_value2 = look2.value;

    // Full is judged on the registered count, so a retiring slot is not
    // reusable until the following cycle.
    assign rob_full     = (count_q == ROB_COUNT_MAX);
    assign issue_fire   = issue_valid && !rob_full && rdy && !flush_q;
    assign issue_rob_id = issue_fire ? tail_q : ROB_ID_NONE;
    assign issue_rd     = issue_has_rd ? issue_rd_in : 5'd0;

    assign head_meta   = meta_q[head_q];
    assign commit_fire = busy_q[head_q] && ready_q[head_q];
    assign mispredict  = head_meta.is_br && (taken_q[head_q] != head_meta.pred_taken);
    assign cdb_hit     = cdb_valid && (cdb_rob_id != ROB_ID_NONE) && busy_q[cdb_rob_id];

    always_comb begin
        busy_d          = busy_q;
        ready_d         = ready_q;
        taken_d         = taken_q;
        value_d         = value_q;
        meta_d          = meta_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_rob_id_d = ROB_ID_NONE;
        commit_rd_d     = 5'd0;
        commit_value_d  = '0;
        flush_d         = 1'b0;
        flush_pc_d      = flush_pc_q;

        if (!rdy) begin
            // frozen: only the one-cycle commit/flush pulses fall away
        end else if (flush_q) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = ROB_ID_FIRST;
            tail_d  = ROB_ID_FIRST;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                value_d[cdb_rob_id] = cdb_value;
                taken_d[cdb_rob_id] = cdb_taken;
                ready_d[cdb_rob_id] = 1'b1;
            end
            if (issue_fire) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                meta_d[tail_q]  = '{rd: issue_rd, is_br: issue_is_br,
                                    pred_taken: issue_pred_taken, alt_pc: issue_alt_pc};
                tail_d          = tail_inc;
            end
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                head_d          = head_inc;
                commit_rob_id_d = head_q;
                commit_value_d  = value_q[head_q];
                commit_rd_d     = mispredict ? 5'd0 : head_meta.rd;
                if (mispredict) begin
                    flush_d    = 1'b1;
                    flush_pc_d = head_meta.alt_pc;
                end
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_d = count_q + rob_id_t'(1);
                2'b01:   count_d = count_q - rob_id_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q          <= '0;
            ready_q         <= '0;
            taken_q         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                value_q[i] <= '0;
                meta_q[i]  <= '0;
            end
            head_q          <= ROB_ID_FIRST;
            tail_q          <= ROB_ID_FIRST;
            count_q         <= '0;
            commit_rob_id_q <= ROB_ID_NONE;
            commit_rd_q     <= 5'd0;
            commit_value_q  <= '0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            taken_q         <= taken_d;
            value_q         <= value_d;
            meta_q          <= meta_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            flush_q         <= flush_d;
            flush_pc_q      <= flush_pc_d;
        end
    end

    assign commit_rob_id = commit_rob_id_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_rob_buffer.sv
// Directed and randomized bench for rob_buffer against an in-order queue model.
module tb_rob_buffer;
    import rob_buffer_pkg::*;

    localparam int W = ROB_SIZE_WIDTH;
    localparam int N = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n, rdy;
    logic          issue_valid, issue_has_rd, issue_is_br, issue_pred_taken;
    logic [4:0]    issue_rd_in;
    logic [31:0]   issue_alt_pc;
    logic          rob_full;
    logic [W-1:0]  issue_rob_id;
    logic [4:0]    issue_rd;
    logic          cdb_valid, cdb_taken;
    logic [W-1:0]  cdb_rob_id, ask_rob_id1, ask_rob_id2;
    logic [31:0]   cdb_value;
    logic [31:0]   get_value1, get_value2;
    logic          get_ready1, get_ready2;
    logic [W-1:0]  commit_rob_id;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;
    logic          flush;
    logic [31:0]   flush_pc;

    rob_buffer dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd_in(issue_rd_in),
        .issue_is_br(issue_is_br), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .rob_full(rob_full),
        .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
        .get_value1(get_value1), .get_value2(get_value2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program-order queue of in-flight ids plus per-id fields.
    int          q[$];
    int          m_tail;
    logic [4:0]  m_rd   [8];
    bit          m_br   [8];
    bit          m_pred [8];
    bit          m_taken[8];
    bit          m_rdy  [8];
    logic [31:0] m_alt  [8];
    logic [31:0] m_val  [8];
    int          m_cid;
    logic [4:0]  m_crd;
    logic [31:0] m_cval;
    bit          m_flush;
    logic [31:0] m_fpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input int id);
        foreach (q[i]) if (q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 1;
        for (int i = 0; i < 8; i++) begin
            m_rd[i] = 0; m_br[i] = 0; m_pred[i] = 0; m_taken[i] = 0;
            m_rdy[i] = 0; m_alt[i] = 0; m_val[i] = 0;
        end
        m_cid = 0; m_crd = 0; m_cval = 0; m_flush = 0; m_fpc = 0;
    endtask

    task automatic exp_lookup(input int id, output logic r, output logic [31:0] v);
        r = 1'b0; v = 32'h0;
        if (id != 0) begin
            r = m_rdy[id]; v = m_val[id];
`ifdef ROB_BYPASS_EN
            if (cdb_valid && int'(cdb_rob_id) == id) begin r = 1'b1; v = cdb_value; end
`endif
        end
    endtask

    task automatic check_outputs();
        bit          full;
        int          iid;
        logic        r;
        logic [31:0] v;
        full = (q.size() == N);
        iid  = (issue_valid && !full && rdy && !m_flush) ? m_tail : 0;
        chk("rob_full", rob_full, full);
        chk("issue_rob_id", issue_rob_id, iid);
        chk("issue_rd", issue_rd, issue_has_rd ? issue_rd_in : 5'd0);
        exp_lookup(int'(ask_rob_id1), r, v);
        chk("get_ready1", get_ready1, r);
        chk("get_value1", get_value1, v);
        exp_lookup(int'(ask_rob_id2), r, v);
        chk("get_ready2", get_ready2, r);
        chk("get_value2", get_value2, v);
        chk("commit_rob_id", commit_rob_id, m_cid);
        chk("commit_rd", commit_rd, m_crd);
        chk("commit_value", commit_value, m_cval);
        chk("flush", flush, m_flush);
        chk("flush_pc", flush_pc, m_fpc);
    endtask

    task automatic model_edge();
        bit do_issue, do_commit, cdb_ok, mis;
        int h, c, t;
        if (!rst_n) return;
        if (!rdy) begin
            m_cid = 0; m_crd = 0; m_cval = 0; m_flush = 0;
            return;
        end
        if (m_flush) begin
            q.delete();
            m_tail = 1;
            for (int i = 0; i < 8; i++) m_rdy[i] = 0;
            m_cid = 0; m_crd = 0; m_cval = 0; m_flush = 0;
            return;
        end
        do_issue  = issue_valid && (q.size() != N);
        do_commit = (q.size() > 0) && m_rdy[q[0]];
        c         = int'(cdb_rob_id);
        cdb_ok    = cdb_valid && c != 0 && in_q(c);
        if (do_commit) begin
            h      = q.pop_front();
            mis    = m_br[h] && (m_taken[h] != m_pred[h]);
            m_cid  = h;
            m_cval = m_val[h];
            m_crd  = mis ? 5'd0 : m_rd[h];
            m_flush = mis;
            if (mis) m_fpc = m_alt[h];
        end else begin
            m_cid = 0; m_crd = 0; m_cval = 0; m_flush = 0;
        end
        if (cdb_ok) begin
            m_val[c] = cdb_value; m_taken[c] = cdb_taken; m_rdy[c] = 1'b1;
        end
        if (do_issue) begin
            t = m_tail;
            q.push_back(t);
            m_rd[t]   = issue_has_rd ? issue_rd_in : 5'd0;
            m_br[t]   = issue_is_br;
            m_pred[t] = issue_pred_taken;
            m_alt[t]  = issue_alt_pc;
            m_rdy[t]  = 1'b0;
            m_tail    = (m_tail == N) ? 1 : m_tail + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_has_rd = 0; issue_rd_in = 0; issue_is_br = 0;
        issue_pred_taken = 0; issue_alt_pc = 0;
        cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0; cdb_taken = 0;
        ask_rob_id1 = 0; ask_rob_id2 = 0; rdy = 1;
    endtask

    task automatic set_issue(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] alt);
        issue_valid = 1; issue_has_rd = (rd != 0); issue_rd_in = rd;
        issue_is_br = br; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic set_cdb(input int id, input logic [31:0] val, input bit tk);
        cdb_valid = 1; cdb_rob_id = W'(id); cdb_value = val; cdb_taken = tk;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        tick();
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;

        // Three issues with rd=5 receive ids 1,2,3
        for (int i = 0; i < 3; i++) begin set_issue(5, 0, 0, 0); tick(); end
        idle(); ask_rob_id1 = 1; ask_rob_id2 = 3; tick();

        // Fill to full, hold the 8th, then retire id1 while full
        for (int i = 0; i < 5; i++) begin set_issue(5'(i + 1), 0, 0, 0); tick(); end
        idle(); set_cdb(1, 32'h11, 0); tick();
        idle(); set_issue(9, 0, 0, 0); tick();
        tick();
        idle(); tick();

        // Out-of-order completion, in-order retirement
        do_reset();
        set_issue(3, 0, 0, 0); tick();
        set_issue(4, 0, 0, 0); tick();
        idle(); set_cdb(2, 32'h55, 0); tick();
        idle(); tick();
        set_cdb(1, 32'h11, 0); tick();
        idle(); tick(); tick(); tick();

        // Mispredicted branch at the head redirects and clears the machine
        do_reset();
        set_issue(0, 1, 0, 32'h100); tick();
        set_issue(7, 0, 0, 0); tick();
        idle(); set_cdb(2, 32'h22, 0); tick();
        set_cdb(1, 32'h0, 1); tick();
        idle(); ask_rob_id1 = 2; tick();
        set_issue(6, 0, 0, 0); ask_rob_id1 = 2; ask_rob_id2 = 1; tick();
        set_issue(6, 0, 0, 0); tick();
        idle(); ask_rob_id1 = 2; tick();

        // Same-cycle CDB to an asked id
        do_reset();
        for (int i = 0; i < 3; i++) begin set_issue(8, 0, 0, 0); tick(); end
        idle(); ask_rob_id1 = 3; ask_rob_id2 = 0; set_cdb(3, 32'hAB, 0); tick();
        idle(); ask_rob_id1 = 3; tick();

        // Freeze with rdy low while issue and CDB are active
        set_cdb(1, 32'h77, 0); tick();
        for (int i = 0; i < 4; i++) begin
            set_issue(2, 0, 0, 0); set_cdb(2, 32'h99, 0); ask_rob_id1 = 2; rdy = 0; tick();
        end
        idle(); tick(); tick();

        // Asynchronous reset in the middle of traffic
        set_issue(1, 0, 0, 0); tick();
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        idle(); tick();
        rst_n = 1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                set_issue(5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1, $urandom());
            if ($urandom_range(0, 9) < 6) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    set_cdb(q[$urandom_range(0, q.size() - 1)], $urandom(), $urandom_range(0, 1) == 1);
                else
                    set_cdb($urandom_range(0, N), $urandom(), $urandom_range(0, 1) == 1);
            end
            ask_rob_id1 = W'($urandom_range(0, N));
            ask_rob_id2 = (cdb_valid && $urandom_range(0, 1) == 1) ? cdb_rob_id : W'($urandom_range(0, N));
            tick();
        end

        idle(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
